// File: rtl/or_arb.sv
// or_arb: 4-way round-robin arbiter for a shared OR datapath; OR_ARB_TIMEOUT_EN adds a grant watchdog.
module or_arb #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic       busy,
  output logic       tout
);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_e;
  state_e     state_q;
  logic [1:0] ptr_q, owner_q, win_d;
  logic [3:0] grant_q, rot;
  logic       busy_q, tout_q, rel_d, to_d;
  // rotate so bit 0 is the requester at ptr, then map the winner back
  assign rot = 4'({req, req} >> ptr_q);
  assign win_d = ptr_q + (rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3);
  assign rel_d = done || !req[owner_q];
`ifdef OR_ARB_TIMEOUT_EN
  logic [3:0] cnt_q;
  assign to_d = cnt_q == 4'(TIMEOUT - 1);
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign to_d = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      owner_q <= 2'd0;
      grant_q <= 4'd0;
      busy_q  <= 1'b0;
      tout_q  <= 1'b0;
`ifdef OR_ARB_TIMEOUT_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      tout_q <= 1'b0;
      case (state_q)
        IDLE: if (|req) begin
          owner_q <= win_d;
          grant_q <= 4'b1 << win_d;
          busy_q  <= 1'b1;
          state_q <= GRANT;
`ifdef OR_ARB_TIMEOUT_EN
          cnt_q   <= 4'd0;
`endif
        end
        GRANT: if (rel_d || to_d) begin
          grant_q <= 4'd0;
          busy_q  <= 1'b0;
          ptr_q   <= owner_q + 2'd1;
          tout_q  <= !rel_d;
          state_q <= RELEASE;
        end else begin
`ifdef OR_ARB_TIMEOUT_EN
          cnt_q   <= cnt_q + 4'd1;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign grant = grant_q;
  assign busy  = busy_q;
  assign tout  = tout_q;
endmodule

// File: tb/tb_or_arb.sv
// tb_or_arb: directed and random stimulus checked against a behavioural arbiter model.
module tb_or_arb;
  localparam int TO = 3;
  logic clk = 1'b0, rst = 1'b1, done = 1'b0, busy, tout;
  logic [3:0] req = 4'd0, grant;
  int checks = 0, errors = 0;
  int m_owner = -1, m_ptr = 0, m_age = 0;
  bit m_rel = 0, m_tout = 0;
`ifdef OR_ARB_TIMEOUT_EN
  localparam bit TE = 1'b1;
`else
  localparam bit TE = 1'b0;
`endif

  or_arb #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant), .busy(busy), .tout(tout));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [3:0] r, input logic d, input logic rs);
    m_tout = 0;
    if (rs) begin
      m_owner = -1; m_ptr = 0; m_rel = 0; m_age = 0;
    end else if (m_owner >= 0) begin
      m_age++;
      if (d || !r[m_owner] || (TE && m_age == TO)) begin
        m_tout = !d && r[m_owner];
        m_ptr = (m_owner + 1) % 4;
        m_owner = -1;
        m_rel = 1;
      end
    end else if (m_rel) begin
      m_rel = 0;
    end else if (r != 0) begin
      for (int k = 3; k >= 0; k--)
        if (r[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
      m_age = 0;
    end
  endfunction

  task automatic step(input logic [3:0] r, input logic d, input logic rs);
    logic [3:0] eg;
    req = r; done = d; rst = rs;
    @(posedge clk);
    model(r, d, rs);
    #1;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
    chk("grant", grant, eg);
    chk("busy", {3'd0, busy}, {3'd0, |eg});
    chk("tout", {3'd0, tout}, {3'd0, m_tout});
  endtask

  initial begin
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    chk("reset_grant", grant, 4'b0000);
    step(4'b1010, 1'b0, 1'b0);
    chk("first_owner", grant, 4'b0010);
    step(4'b1010, 1'b0, 1'b0);
    step(4'b1010, 1'b1, 1'b0);
    chk("release_gap1", grant, 4'b0000);
    step(4'b1010, 1'b0, 1'b0);
    chk("release_gap2", grant, 4'b0000);
    step(4'b1010, 1'b1, 1'b0);
    chk("skip_absent", grant, 4'b1000);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++) begin
      step(4'b1111, 1'b0, 1'b0);
      chk("rr_seq", grant, 4'(1 << (n % 4)));
      step(4'b1111, 1'b0, 1'b0);
      step(4'b1111, 1'b0, 1'b0);
      step(4'b1111, 1'b1, 1'b0);
      step(4'b1111, 1'b0, 1'b0);
    end
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0);
    chk("mid_grant", grant, 4'b0100);
    step(4'b0100, 1'b0, 1'b1);
    chk("rst_mid_grant", grant, 4'b0000);
    step(4'b0100, 1'b0, 1'b0);
    chk("regrant_after_rst", grant, 4'b0100);
    step(4'b0000, 1'b0, 1'b1);
`ifdef OR_ARB_TIMEOUT_EN
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    chk("held_3", grant, 4'b0001);
    step(4'b0001, 1'b0, 1'b0);
    chk("tout_pulse", {3'd0, tout}, 4'b0001);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    chk("done_wins", {3'd0, tout}, 4'b0000);
`else
    for (int n = 0; n < 100; n++) step(4'b0100, 1'b0, 1'b0);
    chk("held_100", grant, 4'b0100);
    chk("no_tout", {3'd0, tout}, 4'b0000);
`endif
    for (int n = 0; n < 600; n++)
      step(4'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 60) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
